// File: rtl/burst_mem_ctrl.sv
// burst_mem_ctrl: single-port burst memory with valid/ready handshakes on the
// request, write-data and read-data channels. A request starts one burst of
// BURST_LEN beats at word address (req_addr*BURST_LEN + beat) mod MEM_DEPTH.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   req_valid/req_ready    request handshake; req_write selects write (1) / read (0)
//   req_addr               burst (line) address
//   wr_valid/wr_ready      write beat handshake, wr_data carries the beat
//   rd_valid/rd_ready      read beat handshake, rd_data carries the beat
//   rd_last                final beat of a read burst
//   busy                   a burst is in progress
//   err                    only with BURST_MEM_ERR_EN: one-cycle pulse when a
//                          request addresses beyond MEM_DEPTH (request dropped)
//
// Optional feature macro: BURST_MEM_ERR_EN
module burst_mem_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MEM_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy
`ifdef BURST_MEM_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  // One extra bit so "all beats issued" is representable during a read.
  localparam int unsigned CNT_W  = BEAT_W + 1;
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  // Storage (never reset)
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Registers
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_last_q, rd_last_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  // Handshake / datapath helpers
  logic [MEM_AW-1:0] word_addr;
  logic              req_fire;
  logic              wr_fire;
  logic              rd_fire;
  logic              rd_load;
  logic              addr_oor;

  // Line address concatenated with beat index equals addr*BURST_LEN+beat;
  // the width cast truncates (wraps) or zero-extends to the memory index.
  assign word_addr = MEM_AW'({addr_q, beat_q[BEAT_W-1:0]});

  assign req_fire = (state_q == S_IDLE)  && req_valid && req_ready_q;
  assign wr_fire  = (state_q == S_WRITE) && wr_valid  && wr_ready_q;
  assign rd_fire  = (state_q == S_READ)  && rd_valid_q && rd_ready;
  // Output register may refill when empty or being drained, while beats remain.
  assign rd_load  = (state_q == S_READ) && (!rd_valid_q || rd_ready) &&
                    (beat_q < CNT_W'(BURST_LEN));

`ifdef BURST_MEM_ERR_EN
  assign addr_oor = (32'(req_addr) * BURST_LEN) >= MEM_DEPTH;
`else
  assign addr_oor = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d = rd_data_q;
    rd_last_d = rd_last_q;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          addr_d = req_addr;
          beat_d = '0;
          if (addr_oor) begin
            err_d = 1'b1;
          end else if (req_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_WRITE: begin
        if (wr_fire) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == CNT_W'(BURST_LEN - 1)) begin
            state_d = S_IDLE;
          end
        end
      end

      S_READ: begin
        if (rd_load) begin
          rd_data_d  = mem[word_addr];
          rd_valid_d = 1'b1;
          rd_last_d  = (beat_q == CNT_W'(BURST_LEN - 1));
          beat_d     = beat_q + CNT_W'(1);
        end else if (rd_fire) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // req_ready stays low for the err pulse cycle, so a rejected request
    // leaves a one-cycle gap just like a completed burst.
    req_ready_d = (state_d == S_IDLE) && !err_d;
    wr_ready_d  = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      addr_q      <= '0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Memory write port; reset blocks a beat presented in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem[word_addr] <= wr_data;
    end
  end

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;

`ifdef BURST_MEM_ERR_EN
  assign err = err_q;
`else
  // err_q only matters when the error port exists.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Testbench for burst_mem_ctrl (default parameters). A memory model indexed by
// word address tracks what was written; read bursts queue the model's words
// and a per-cycle monitor checks every read handshake and stall against it.
module tb_burst_mem_ctrl;

  localparam int BL    = 4;
  localparam int DEPTH = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       busy;
`ifdef BURST_MEM_ERR_EN
  logic       err;
`endif

  burst_mem_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .busy     (busy)
`ifdef BURST_MEM_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cnt = 0;

  logic [7:0] model_mem [DEPTH];
  logic [7:0] exp_d [$];
  logic       exp_l [$];
  logic [7:0] got_q [$];
  int         got_cyc [$];

  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic int waddr(input logic [7:0] a, input int b);
    return (int'(a) * BL + b) % DEPTH;
  endfunction

  // Read-channel monitor: every handshake must deliver the next queued word.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, prev_data);
        check("stall_last", rd_last, prev_last);
      end
      if (busy) check("busy_req_ready_low", req_ready, 0);
      if (rd_valid && rd_ready) begin
        hs_cnt++;
        got_q.push_back(rd_data);
        got_cyc.push_back(cyc);
        if (exp_d.size() == 0) begin
          fail("rd_unexpected_beat");
        end else begin
          check("rd_data", rd_data, exp_d.pop_front());
          check("rd_last", rd_last, exp_l.pop_front());
        end
      end
      stall_prev = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; returns #1 after the accept edge.
  task automatic send_req(input logic w, input logic [7:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail("req_accept");
    acc_cyc = cyc;
    step();
    req_valid = 1'b0;
  endtask

  // Write BL beats of base+beat; vpat bit c says whether wr_valid is driven in cycle c.
  task automatic write_burst(input logic [7:0] a, input logic [7:0] base, input logic [15:0] vpat);
    int beat = 0;
    int c = 0;
    send_req(1'b1, a);
    while (beat < BL && c < 16) begin
      wr_valid = vpat[c];
      wr_data  = base + 8'(beat);
      @(negedge clk);
      if (wr_valid) begin
        check("wr_ready", wr_ready, 1);
        model_mem[waddr(a, beat)] = wr_data;
        beat++;
      end else begin
        check("wr_gap_busy", busy, 1);
      end
      step();
      c++;
    end
    wr_valid = 1'b0;
    if (beat < BL) fail("wr_beats");
    check("wr_done_busy", busy, 0);
    check("wr_done_wr_ready", wr_ready, 0);
    check("wr_done_req_ready", req_ready, 1);
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready high one cycle in three.
  task automatic read_burst(input logic [7:0] a, input int mode);
    int c = 0;
    got_q.delete();
    got_cyc.delete();
    hs_cnt = 0;
    for (int b = 0; b < BL; b++) begin
      exp_d.push_back(model_mem[waddr(a, b)]);
      exp_l.push_back(b == BL - 1);
    end
    send_req(1'b0, a);
    check("rd_first_cycle_empty", rd_valid, 0);
    while (exp_d.size() > 0 && c < 40) begin
      rd_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      step();
      c++;
    end
    rd_ready = 1'b0;
    if (exp_d.size() > 0) begin
      fail("rd_beats");
      exp_d.delete();
      exp_l.delete();
    end
    check("rd_handshakes", hs_cnt, BL);
    check("rd_done_busy", busy, 0);
    check("rd_done_valid", rd_valid, 0);
    check("rd_done_last", rd_last, 0);
    check("rd_done_req_ready", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    step(); step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check("post_reset_req_ready", req_ready, 1);

    // Basic write then full-rate read at 0x05 (words 0x14..0x17)
    write_burst(8'h05, 8'hA0, 16'hFFFF);
    read_burst(8'h05, 0);
    check("lit_beats", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("lit_a0", got_q[0], 8'hA0);
      check("lit_a3", got_q[3], 8'hA3);
      check("lit_latency", got_cyc[0] - acc_cyc, 2);
      check("lit_back_to_back", got_cyc[3] - got_cyc[0], 3);
    end

    // Backpressured read of the same burst
    read_burst(8'h05, 1);
    if (got_q.size() == 4) check("lit_stall_a2", got_q[2], 8'hA2);

    // Write with wr_valid only on cycles 0,2,3,6
    write_burst(8'h30, 8'hC0, 16'h004D);
    read_burst(8'h30, 0);
    if (got_q.size() == 4) check("lit_gap_c1", got_q[1], 8'hC1);

    // Reset after two beats of a write to 0x10 (words 0x40..0x43)
    write_burst(8'h10, 8'h50, 16'hFFFF);
    send_req(1'b1, 8'h10);
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hB0 + 8'(b);
      @(negedge clk);
      check("abort_wr_ready", wr_ready, 1);
      model_mem[waddr(8'h10, b)] = wr_data;
      step();
    end
    wr_data = 8'hEE;
    rst = 1'b1;
    step();
    check_reset_outputs("abort");
    rst = 1'b0;
    wr_valid = 1'b0;
    step();
    check("abort_req_ready", req_ready, 1);
    read_burst(8'h10, 0);
    if (got_q.size() == 4) begin
      check("lit_abort_w40", got_q[0], 8'hB0);
      check("lit_abort_w41", got_q[1], 8'hB1);
      check("lit_abort_w42", got_q[2], 8'h52);
      check("lit_abort_w43", got_q[3], 8'h53);
    end

`ifdef BURST_MEM_ERR_EN
    // Out-of-range request: err pulse, no burst
    send_req(1'b0, 8'h80);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_rd_valid", rd_valid, 0);
    check("err_req_ready", req_ready, 0);
    step();
    check("err_clear", err, 0);
    check("err_rd_valid2", rd_valid, 0);
    check("err_req_ready_back", req_ready, 1);
`else
    // Line 0x80 maps to word 512, which wraps to word 0
    write_burst(8'h80, 8'h11, 16'hFFFF);
    read_burst(8'h00, 0);
    if (got_q.size() == 4) begin
      check("lit_wrap_w0", got_q[0], 8'h11);
      check("lit_wrap_w3", got_q[3], 8'h14);
    end
`endif

    // Back-to-back write requests with req_valid held
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20;
    begin
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!req_ready) fail("b2b_first_accept");
    end
    step();
    req_addr = 8'h21;
    for (int b = 0; b < BL; b++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hD0 + 8'(b);
      @(negedge clk);
      check("b2b_req_ready_low", req_ready, 0);
      check("b2b_wr_ready", wr_ready, 1);
      model_mem[waddr(8'h20, b)] = wr_data;
      step();
    end
    wr_valid = 1'b0;
    check("b2b_idle_gap_busy", busy, 0);
    check("b2b_idle_gap_req_ready", req_ready, 1);
    step();
    check("b2b_second_busy", busy, 1);
    check("b2b_second_wr_ready", wr_ready, 1);
    check("b2b_second_req_ready", req_ready, 0);
    req_valid = 1'b0;
    for (int b = 0; b < BL; b++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hE0 + 8'(b);
      @(negedge clk);
      check("b2b2_wr_ready", wr_ready, 1);
      model_mem[waddr(8'h21, b)] = wr_data;
      step();
    end
    wr_valid = 1'b0;
    check("b2b2_done_busy", busy, 0);
    read_burst(8'h20, 0);
    if (got_q.size() == 4) check("lit_b2b_d3", got_q[3], 8'hD3);
    read_burst(8'h21, 1);
    if (got_q.size() == 4) check("lit_b2b_e0", got_q[0], 8'hE0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
